fb_port_arbiter: RTL and testbench
==================================

# fb_port_arbiter

Single-clock arbiter sharing one single-port 320x240x16 RGB565 frame-buffer RAM between the display read path (which feeds the 2x upscaler) and a pixel writer such as the camera capture path. Display reads have absolute priority so active video never stalls. Writer traffic is absorbed by a small FIFO and drained in free cycles; with 2x upscaling, at most every second pixel needs a read. The block sits between the VGA timing/upscaler logic and the frame-buffer BRAM.

## Interface
Parameters:
- ADDR_W, 17, frame-buffer word address width (clog2(320*240)).
- DATA_W, 16, pixel width (RGB565).
- FIFO_DEPTH, 8, write FIFO entries (power of two, ≥2).
- STARVE_LIMIT, 64, consecutive FIFO-full cycles before `wr_starve` sets.

Ports:
- clk  in  1  system/pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- rd_req  in  1  display read request, one cycle per request.
- rd_addr  in  ADDR_W  read address, sampled with rd_req.
- rd_data  out  DATA_W  registered read data, held until the next read returns.
- rd_valid  out  1  one-cycle pulse when rd_data updates.
- wr_valid  in  1  writer has a pixel.
- wr_ready  out  1  FIFO can accept; transfer on wr_valid && wr_ready.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write pixel.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after a read is issued.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- wr_starve  out  1  sticky starvation flag.

## Operation
- Each cycle one grant: GNT_RD if rd_req; else GNT_WR if FIFO non-empty; else GNT_IDLE.
- GNT_RD: mem_en=1, mem_we=0, mem_addr=rd_addr. Combinational, same cycle.
- GNT_WR: mem_en=1, mem_we=1, mem_addr/mem_wdata = FIFO head; head pops at the clock edge.
- GNT_IDLE: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Read return uses a 2-stage pending-read shift: stage-2 loads rd_data from mem_rdata and pulses rd_valid.
- FIFO:
  - wr_ready = (fifo_level < FIFO_DEPTH); no full-cycle pass-through.
  - Push and pop in the same cycle leaves the level unchanged.
  - Writes are committed in acceptance order.
  - A read and a queued write to the same address in the same cycle: the read returns old RAM data.
- Starvation counter:
  - Increments while fifo_level == FIFO_DEPTH && rd_req; clears otherwise.
  - Saturates at STARVE_LIMIT.
  - Reaching STARVE_LIMIT sets wr_starve, which stays set until reset.
- Address range (< 76800) is the caller's responsibility and is not checked.

## Timing
- Reset (async assert, sync release) values:
  - rd_data=0, rd_valid=0, fifo_level=0, wr_starve=0, pending pipeline empty, starvation counter 0.
  - mem_en=0 and wr_ready=0 while reset_n is low.
  - wr_ready=1 from the first cycle after release.
- Read latency: rd_req in cycle N → RAM access in N → mem_rdata in N+1 → rd_valid/rd_data in N+2.
- Back-to-back rd_req is fully pipelined: one rd_valid per request, in order.
- Write latency: accepted in cycle N → earliest RAM write in N+1, if rd_req is low then.
- Reset mid-operation flushes FIFO contents and pending reads; no rd_valid follows.

## Structure
- Package fb_pkg:
  - H_SIZE=320, V_SIZE=240, FB_WORDS, ADDR_W, DATA_W.
  - typedef enum logic [1:0] {GNT_IDLE, GNT_RD, GNT_WR} fb_grant_e.
  - typedef struct packed {addr, data} fb_wr_t.
- Sub-module fb_wr_fifo: synchronous FIFO of fb_wr_t with push/pop/level/full/empty, same reset.
- Arbiter top: grant logic, read-return pipeline, starvation counter.

## Test plan
- Reset, then rd_req at addr 0x00000 with RAM model word 0xF800 → mem_en=1/mem_we=0 that cycle; rd_valid and rd_data=0xF800 two cycles later.
- Push 3 writes (addr 5/6/7, data 0x1111/0x2222/0x3333) with rd_req low → RAM written in order on the 3 following cycles; fifo_level returns to 0.
- rd_req every other cycle while writer streams continuously → alternating GNT_RD/GNT_WR; reads keep 2-cycle latency; no write lost; wr_ready never drops.
- rd_req held high 100 cycles while 8 writes are pushed → wr_ready=0 at level 8; wr_starve sets after 64 full cycles; all 8 writes drain after rd_req drops.
- Assert reset_n low mid-stream with 4 entries queued and 2 reads pending → no rd_valid, no RAM writes; fifo_level=0 after release.
- Same-cycle rd_req to addr 10 and queued write to addr 10 (old 0xAAAA, new 0x5555) → read returns 0xAAAA; next read of addr 10 returns 0x5555.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry, grant encoding and the queued-write record
// used by the port arbiter and its write FIFO.
package fb_pkg;

  localparam int unsigned H_SIZE   = 320;
  localparam int unsigned V_SIZE   = 240;
  localparam int unsigned FB_WORDS = H_SIZE * V_SIZE;
  localparam int unsigned ADDR_W   = $clog2(FB_WORDS);
  localparam int unsigned DATA_W   = 16;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_RD,
    GNT_WR
  } fb_grant_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } fb_wr_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO of pending frame-buffer writes. A push while full is
// dropped and a pop while empty is ignored; the caller gates both.
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  fb_wr_t                 push_data,
  input  logic                   pop,
  output fb_wr_t                 head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  fb_wr_t           mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    level_q;
  logic             do_push, do_pop;

  assign full    = (level_q == (PtrW + 1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rptr_q];
  assign level   = level_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (PtrW + 1)'(1);
        2'b01:   level_q <= level_q - (PtrW + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data;
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Shares the single-port frame-buffer RAM between display reads (absolute
// priority) and a FIFO-buffered pixel writer drained in free cycles.
module fb_port_arbiter #(
  parameter int unsigned ADDR_W       = 17,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned STARVE_LIMIT = 64
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        rd_req,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        rd_valid,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        wr_starve
);

  import fb_pkg::*;

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  fb_grant_e         grant;
  fb_wr_t            wr_entry, wr_head;
  logic              fifo_full, fifo_empty;
  logic              rd_pend_q, rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [CntW-1:0]   starve_cnt_q, starve_cnt_d;
  logic              starve_q;

  assign wr_entry = '{addr: wr_addr, data: wr_data};

  // Held in reset, nothing reaches the RAM and the writer is refused.
  assign wr_ready = reset_n && !fifo_full;

  fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (wr_valid && wr_ready),
    .push_data (wr_entry),
    .pop       (grant == GNT_WR),
    .head      (wr_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    grant = GNT_IDLE;
    if (!reset_n)         grant = GNT_IDLE;
    else if (rd_req)      grant = GNT_RD;
    else if (!fifo_empty) grant = GNT_WR;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (grant)
      GNT_RD: begin
        mem_en   = 1'b1;
        mem_addr = rd_addr;
      end
      GNT_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wr_head.addr;
        mem_wdata = wr_head.data;
      end
      default: ;
    endcase
  end

  // Read return: stage 1 waits out the RAM latency, stage 2 captures the word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_pend_q  <= (grant == GNT_RD);
      rd_valid_q <= rd_pend_q;
      if (rd_pend_q) rd_data_q <= mem_rdata;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

  always_comb begin
    starve_cnt_d = '0;
    if (fifo_full && rd_req) begin
      starve_cnt_d = (starve_cnt_q == CntW'(STARVE_LIMIT)) ? starve_cnt_q
                                                           : starve_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      if (starve_cnt_d == CntW'(STARVE_LIMIT)) starve_q <= 1'b1;
    end
  end

  assign wr_starve = starve_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a behavioural synchronous RAM model.
module tb_fb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rd_req = 1'b0;
  logic [16:0] rd_addr = '0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [16:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        mem_en, mem_we;
  logic [16:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic [3:0]  fifo_level;
  logic        wr_starve;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] ram [0:(1<<17)-1];

  logic [15:0] alt_exp [5];
  logic [16:0] alt_adr [5];

  always #5 clk = ~clk;

  fb_port_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .fifo_level (fifo_level),
    .wr_starve  (wr_starve)
  );

  // Synchronous single-port RAM: read data appears the cycle after the access.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] = mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < (1 << 17); i++) ram[i] = 16'h0000;
    ram[0]  = 16'hF800;
    ram[10] = 16'hAAAA;
    alt_exp = '{16'h1111, 16'h2222, 16'h3333, 16'hF800, 16'hAAAA};
    alt_adr = '{17'd5, 17'd6, 17'd7, 17'd0, 17'd10};

    // Reset: requests must not reach the RAM.
    rd_req = 1'b1;
    tick(); tick();
    check("rst_mem_en", mem_en, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    rd_req  = 1'b0;
    reset_n = 1'b1;
    #1;
    check("rel_wr_ready", wr_ready, 1);
    check("rel_level", fifo_level, 0);
    check("rel_rd_data", rd_data, 0);
    check("rel_starve", wr_starve, 0);
    tick();

    // Single read, two-cycle latency.
    rd_req = 1'b1; rd_addr = 17'd0;
    #1;
    check("rd_mem_en", mem_en, 1);
    check("rd_mem_we", mem_we, 0);
    check("rd_mem_addr", mem_addr, 0);
    tick();
    rd_req = 1'b0;
    #1;
    check("rd_valid_n1", rd_valid, 0);
    tick();
    check("rd_valid_n2", rd_valid, 1);
    check("rd_data_n2", rd_data, 16'hF800);
    tick();
    check("rd_valid_n3", rd_valid, 0);
    check("rd_data_hold", rd_data, 16'hF800);

    // Three writes committed in order on the following cycles.
    wr_valid = 1'b1; wr_addr = 17'd5; wr_data = 16'h1111;
    tick();
    wr_addr = 17'd6; wr_data = 16'h2222;
    #1;
    check("w1_we", mem_we, 1);
    check("w1_addr", mem_addr, 5);
    check("w1_data", mem_wdata, 16'h1111);
    check("w1_level", fifo_level, 1);
    tick();
    wr_addr = 17'd7; wr_data = 16'h3333;
    #1;
    check("w2_addr", mem_addr, 6);
    tick();
    wr_valid = 1'b0;
    #1;
    check("w3_addr", mem_addr, 7);
    check("w3_data", mem_wdata, 16'h3333);
    tick();
    check("w_level0", fifo_level, 0);
    check("w_idle", mem_en, 0);
    check("w_ram5", ram[5], 16'h1111);
    check("w_ram7", ram[7], 16'h3333);

    // Reads every other cycle against a continuous writer.
    for (int k = 0; k < 10; k++) begin
      rd_req   = (k % 2 == 0);
      rd_addr  = alt_adr[k/2];
      wr_valid = 1'b1;
      wr_addr  = 17'(20 + k);
      wr_data  = 16'(16'hB000 + k);
      #1;
      check("alt_ready", wr_ready, 1);
      check("alt_we", mem_we, 32'(k % 2));
      if (k % 2 == 1) check("alt_waddr", mem_addr, 32'(20 + (k - 1) / 2));
      check("alt_rvalid", rd_valid, 32'(k >= 2 && k % 2 == 0));
      if (k >= 2 && k % 2 == 0) check("alt_rdata", rd_data, alt_exp[k/2-1]);
      tick();
    end
    rd_req = 1'b0; wr_valid = 1'b0;
    #1;
    check("alt_last_valid", rd_valid, 1);
    check("alt_last_data", rd_data, 16'hAAAA);
    check("alt_level", fifo_level, 5);
    for (int i = 0; i < 20 && fifo_level != 0; i++) tick();
    check("alt_drain", fifo_level, 0);
    for (int i = 0; i < 10; i++) check("alt_ram", ram[20+i], 32'(16'hB000 + i));

    // Reads hold the port for 100 cycles while the FIFO fills.
    for (int c = 0; c < 100; c++) begin
      rd_req   = 1'b1;
      rd_addr  = 17'd0;
      wr_valid = (c < 8);
      wr_addr  = 17'(30 + c);
      wr_data  = 16'(16'hC000 + c);
      #1;
      if (c == 7)  check("st_ready7", wr_ready, 1);
      if (c == 8)  check("st_ready8", wr_ready, 0);
      if (c == 8)  check("st_level8", fifo_level, 8);
      if (c == 50) check("st_rvalid", rd_valid, 1);
      if (c == 50) check("st_rdata", rd_data, 16'hF800);
      if (c == 71) check("st_starve71", wr_starve, 0);
      if (c == 72) check("st_starve72", wr_starve, 1);
      tick();
    end
    rd_req = 1'b0; wr_valid = 1'b0;
    for (int i = 0; i < 20 && fifo_level != 0; i++) tick();
    check("st_drain", fifo_level, 0);
    for (int i = 0; i < 8; i++) check("st_ram", ram[30+i], 32'(16'hC000 + i));
    check("st_sticky", wr_starve, 1);
    tick();

    // Reset mid-stream with writes queued and reads in flight.
    for (int c = 0; c < 4; c++) begin
      rd_req = 1'b1; rd_addr = 17'd0;
      wr_valid = 1'b1; wr_addr = 17'(40 + c); wr_data = 16'(16'hD000 + c);
      tick();
    end
    check("mr_level4", fifo_level, 4);
    reset_n = 1'b0; rd_req = 1'b0; wr_valid = 1'b0;
    #1;
    check("mr_rvalid_async", rd_valid, 0);
    check("mr_mem_en", mem_en, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mr_rvalid_rst", rd_valid, 0);
      check("mr_we_rst", mem_we, 0);
    end
    reset_n = 1'b1;
    #1;
    check("mr_level0", fifo_level, 0);
    check("mr_starve", wr_starve, 0);
    for (int i = 0; i < 4; i++) begin
      check("mr_rvalid_post", rd_valid, 0);
      check("mr_we_post", mem_we, 0);
      tick();
    end
    check("mr_ram40", ram[40], 0);
    check("mr_ram43", ram[43], 0);

    // Read and queued write to the same address in the same cycle.
    wr_valid = 1'b1; wr_addr = 17'd10; wr_data = 16'h5555;
    tick();
    wr_valid = 1'b0; rd_req = 1'b1; rd_addr = 17'd10;
    #1;
    check("hz_level", fifo_level, 1);
    check("hz_we_blocked", mem_we, 0);
    tick();
    rd_req = 1'b0;
    #1;
    check("hz_we", mem_we, 1);
    check("hz_waddr", mem_addr, 10);
    tick();
    rd_req = 1'b1;
    #1;
    check("hz_old_valid", rd_valid, 1);
    check("hz_old_data", rd_data, 16'hAAAA);
    tick();
    rd_req = 1'b0;
    tick();
    check("hz_new_valid", rd_valid, 1);
    check("hz_new_data", rd_data, 16'h5555);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
